// File: rtl/instr_ctrl.sv
// Instruction register plus Moore FSM sequencing the datapath strobes for
// MOV-immediate, MOV/MVN register, ADD/AND and CMP instructions.
module instr_ctrl #(
  parameter logic IMM_SEXT = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        s,
  input  logic        load,
  input  logic [15:0] in,
  output logic        w,
  output logic        err,
  output logic [2:0]  readnum,
  output logic [2:0]  writenum,
  output logic [1:0]  shift,
  output logic [1:0]  ALUop,
  output logic        loada,
  output logic        loadb,
  output logic        loadc,
  output logic        loads,
  output logic        asel,
  output logic        bsel,
  output logic        write,
  output logic [1:0]  vsel,
  output logic [15:0] sximm8
);

  typedef enum logic [2:0] {
    S_WAIT   = 3'd0,
    S_DECODE = 3'd1,
    S_WR_IMM = 3'd2,
    S_GET_A  = 3'd3,
    S_GET_B  = 3'd4,
    S_ALU    = 3'd5,
    S_WR_REG = 3'd6
  } state_t;

  state_t      state, state_next;
  logic [15:0] ir;

  logic [2:0] opcode;
  logic [1:0] op;
  logic [2:0] rn, rd, rm;
  logic       is_cmp;

  assign opcode = ir[15:13];
  assign op     = ir[12:11];
  assign rn     = ir[10:8];
  assign rd     = ir[7:5];
  assign rm     = ir[2:0];
  assign shift  = ir[4:3];
  assign ALUop  = ir[12:11];
  assign is_cmp = (opcode == 3'b101) && (op == 2'b01);

  generate
    if (IMM_SEXT) begin : g_sext
      assign sximm8 = {{8{ir[7]}}, ir[7:0]};
    end else begin : g_zext
      assign sximm8 = {8'h00, ir[7:0]};
    end
  endgenerate

  // IR loads in any state; a busy instruction picks up the new fields at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_WAIT;
      ir    <= '0;
    end else begin
      state <= state_next;
      if (load) ir <= in;
    end
  end

  always_comb begin
    state_next = state;
    w        = 1'b0;
    err      = 1'b0;
    readnum  = 3'b000;
    writenum = 3'b000;
    loada    = 1'b0;
    loadb    = 1'b0;
    loadc    = 1'b0;
    loads    = 1'b0;
    asel     = 1'b0;
    bsel     = 1'b0;
    write    = 1'b0;
    vsel     = 2'b00;

    unique case (state)
      S_WAIT: begin
        w = 1'b1;
        if (s) state_next = S_DECODE;
      end
      S_DECODE: begin
        unique case ({opcode, op})
          5'b110_10: state_next = S_WR_IMM;
          5'b110_00: state_next = S_GET_B;
          5'b101_11: state_next = S_GET_B;
          5'b101_00,
          5'b101_01,
          5'b101_10: state_next = S_GET_A;
          default: begin
            state_next = S_WAIT;
            err        = 1'b1;
          end
        endcase
      end
      S_WR_IMM: begin
        writenum   = rn;
        vsel       = 2'b10;
        write      = 1'b1;
        state_next = S_WAIT;
      end
      S_GET_A: begin
        readnum    = rn;
        loada      = 1'b1;
        state_next = S_GET_B;
      end
      S_GET_B: begin
        readnum    = rm;
        loadb      = 1'b1;
        state_next = S_ALU;
      end
      S_ALU: begin
        // MOV register has no A operand, so A is forced to zero.
        asel       = (opcode == 3'b110);
        loadc      = !is_cmp;
        loads      = is_cmp;
        state_next = is_cmp ? S_WAIT : S_WR_REG;
      end
      S_WR_REG: begin
        writenum   = rd;
        vsel       = 2'b00;
        write      = 1'b1;
        state_next = S_WAIT;
      end
      default: state_next = S_WAIT;
    endcase
  end

endmodule

// File: tb/tb_instr_ctrl.sv
// Directed self-checking bench for instr_ctrl; two instances cover both
// immediate-extension settings.
module tb_instr_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        s;
  logic        load;
  logic [15:0] in;

  logic        w, err, loada, loadb, loadc, loads, asel, bsel, write;
  logic [2:0]  readnum, writenum;
  logic [1:0]  shift, ALUop, vsel;
  logic [15:0] sximm8;

  logic        z_w, z_err, z_loada, z_loadb, z_loadc, z_loads, z_asel, z_bsel, z_write;
  logic [2:0]  z_readnum, z_writenum;
  logic [1:0]  z_shift, z_ALUop, z_vsel;
  logic [15:0] z_sximm8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instr_ctrl #(.IMM_SEXT(1'b1)) dut (
    .clk(clk), .reset(reset), .s(s), .load(load), .in(in),
    .w(w), .err(err), .readnum(readnum), .writenum(writenum),
    .shift(shift), .ALUop(ALUop), .loada(loada), .loadb(loadb),
    .loadc(loadc), .loads(loads), .asel(asel), .bsel(bsel),
    .write(write), .vsel(vsel), .sximm8(sximm8)
  );

  instr_ctrl #(.IMM_SEXT(1'b0)) dut_z (
    .clk(clk), .reset(reset), .s(s), .load(load), .in(in),
    .w(z_w), .err(z_err), .readnum(z_readnum), .writenum(z_writenum),
    .shift(z_shift), .ALUop(z_ALUop), .loada(z_loada), .loadb(z_loadb),
    .loadc(z_loadc), .loads(z_loads), .asel(z_asel), .bsel(z_bsel),
    .write(z_write), .vsel(z_vsel), .sximm8(z_sximm8)
  );

  // Control vector: {w, err, readnum, writenum, loada, loadb, loadc, loads, asel, bsel, write, vsel}
  logic [16:0] ctl;
  assign ctl = {w, err, readnum, writenum, loada, loadb, loadc, loads,
                asel, bsel, write, vsel};

  function automatic logic [16:0] ev(input logic ew, input logic eerr,
                                     input logic [2:0] ern, input logic [2:0] ewn,
                                     input logic la, input logic lb, input logic lc,
                                     input logic ls, input logic as, input logic bs,
                                     input logic wr, input logic [1:0] vs);
    return {ew, eerr, ern, ewn, la, lb, lc, ls, as, bs, wr, vs};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Load the instruction and pulse s on the same WAIT edge.
  task automatic start(input logic [15:0] instr);
    in   = instr;
    load = 1'b1;
    s    = 1'b1;
    step();
    load = 1'b0;
    s    = 1'b0;
  endtask

  localparam logic [16:0] V_WAIT = 17'h10000;
  localparam logic [16:0] V_BUSY = 17'h00000;

  initial begin
    reset = 1'b0;
    s     = 1'b0;
    load  = 1'b0;
    in    = 16'h0000;
    #2;
    check("reset_ctl", 32'(ctl), 32'(V_WAIT));
    check("reset_imm", 32'(sximm8), 32'h0);
    step();
    reset = 1'b1;
    step();
    check("idle_wait", 32'(ctl), 32'(V_WAIT));

    // MOV R1,#3 : 3 edges
    start(16'hD103);
    check("movi_decode", 32'(ctl), 32'(V_BUSY));
    step();
    check("movi_wrimm", 32'(ctl), 32'(ev(0,0,3'd0,3'd1,0,0,0,0,0,0,1,2'b10)));
    check("movi_imm", 32'(sximm8), 32'h0003);
    step();
    check("movi_done", 32'(ctl), 32'(V_WAIT));

    // MOV R6,#-3 extension under both settings
    in = 16'hD6FD; load = 1'b1;
    step();
    load = 1'b0;
    check("imm_sext", 32'(sximm8), 32'h0000FFFD);
    check("imm_zext", 32'(z_sximm8), 32'h000000FD);
    check("load_idle", 32'(ctl), 32'(V_WAIT));

    // ADD R3,R2,R1 LSL1 : 6 edges
    start(16'hA269);
    check("add_decode", 32'(ctl), 32'(V_BUSY));
    check("add_shift", 32'(shift), 32'h1);
    check("add_aluop", 32'(ALUop), 32'h0);
    step();
    check("add_geta", 32'(ctl), 32'(ev(0,0,3'd2,3'd0,1,0,0,0,0,0,0,2'b00)));
    step();
    check("add_getb", 32'(ctl), 32'(ev(0,0,3'd1,3'd0,0,1,0,0,0,0,0,2'b00)));
    step();
    check("add_alu", 32'(ctl), 32'(ev(0,0,3'd0,3'd0,0,0,1,0,0,0,0,2'b00)));
    step();
    check("add_wrreg", 32'(ctl), 32'(ev(0,0,3'd0,3'd3,0,0,0,0,0,0,1,2'b00)));
    step();
    check("add_done", 32'(ctl), 32'(V_WAIT));

    // CMP R3,R4 : 5 edges, no write
    start(16'hAB84);
    check("cmp_decode", 32'(ctl), 32'(V_BUSY));
    check("cmp_aluop", 32'(ALUop), 32'h1);
    step();
    check("cmp_geta", 32'(ctl), 32'(ev(0,0,3'd3,3'd0,1,0,0,0,0,0,0,2'b00)));
    step();
    check("cmp_getb", 32'(ctl), 32'(ev(0,0,3'd4,3'd0,0,1,0,0,0,0,0,2'b00)));
    step();
    check("cmp_alu", 32'(ctl), 32'(ev(0,0,3'd0,3'd0,0,0,0,1,0,0,0,2'b00)));
    step();
    check("cmp_done", 32'(ctl), 32'(V_WAIT));

    // MOV R5,R1 : 5 edges, A forced to zero in ALU
    start(16'hC0A1);
    check("movr_decode", 32'(ctl), 32'(V_BUSY));
    step();
    check("movr_getb", 32'(ctl), 32'(ev(0,0,3'd1,3'd0,0,1,0,0,0,0,0,2'b00)));
    step();
    check("movr_alu", 32'(ctl), 32'(ev(0,0,3'd0,3'd0,0,0,1,0,1,0,0,2'b00)));
    step();
    check("movr_wrreg", 32'(ctl), 32'(ev(0,0,3'd0,3'd5,0,0,0,0,0,0,1,2'b00)));
    step();
    check("movr_done", 32'(ctl), 32'(V_WAIT));

    // Illegal opcode: one-cycle err in DECODE
    start(16'hE000);
    check("ill_decode", 32'(ctl), 32'(ev(0,1,3'd0,3'd0,0,0,0,0,0,0,0,2'b00)));
    step();
    check("ill_done", 32'(ctl), 32'(V_WAIT));

    // Reset asserted in GET_B of an ADD
    start(16'hA269);
    step();
    step();
    check("rst_getb", 32'(ctl), 32'(ev(0,0,3'd1,3'd0,0,1,0,0,0,0,0,2'b00)));
    reset = 1'b0;
    #1;
    check("rst_abort_ctl", 32'(ctl), 32'(V_WAIT));
    check("rst_abort_ir", 32'({shift, ALUop, sximm8}), 32'h0);
    step();
    check("rst_hold_write", 32'(write), 32'h0);
    reset = 1'b1;
    step();
    check("rst_stay_wait", 32'(ctl), 32'(V_WAIT));
    step();
    check("rst_no_write", 32'(write), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not complete, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/instr_ctrl.md
INSTR_CTRL -- requirements
Module: instr_ctrl

Interface
REQ-001 SHALL have parameter: IMM_SEXT, 1, 1 = sign-extend imm8 to 16 bits, 0 = zero-extend.
REQ-002 SHALL have port: clk  in  1  rising-edge clock.
REQ-003 SHALL have port: reset  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port: s  in  1  start request; sampled only in WAIT.
REQ-005 SHALL have port: load  in  1  instruction-register load enable.
REQ-006 SHALL have port: in  in  16  instruction word.
REQ-007 SHALL have ports: w  out  1  idle (high in WAIT only); err  out  1  one-cycle illegal-opcode pulse.
REQ-008 SHALL have ports: readnum, writenum  out  3 each  register-file select; shift  out  2  IR[4:3]; ALUop  out  2  IR[12:11].
REQ-009 SHALL have ports: loada, loadb, loadc, loads, asel, bsel, write  out  1 each  datapath strobes.
REQ-010 SHALL have ports: vsel  out  2  writeback source (00 = C, 10 = sximm8); sximm8  out  16  extended IR[7:0].

Function
REQ-011 SHALL hold a 16-bit IR, written with `in` on any clk edge where load=1, in any state.
REQ-012 SHALL decode IR: opcode = IR[15:13], op = IR[12:11], Rn = IR[10:8], Rd = IR[7:5], Rm = IR[2:0].
REQ-013 SHALL implement states WAIT, DECODE, WR_IMM, GET_A, GET_B, ALU, WR_REG (Moore outputs, registered state).
REQ-014 SHALL transition WAIT->DECODE when s=1, else stay in WAIT; s is ignored in all other states.
REQ-015 SHALL branch from DECODE: 110/10 -> WR_IMM; 110/00 -> GET_B; 101/11 -> GET_B; 101/00, 101/01, 101/10 -> GET_A; any other code -> WAIT with err=1 for that DECODE cycle.
REQ-016 SHALL sequence WR_IMM->WAIT, GET_A->GET_B, GET_B->ALU, and ALU->WR_REG, except CMP (101/01), which takes ALU->WAIT; WR_REG->WAIT.
REQ-017 SHALL drive in WR_IMM: writenum=Rn, vsel=10, write=1.
REQ-018 SHALL drive in GET_A: readnum=Rn, loada=1; in GET_B: readnum=Rm, loadb=1.
REQ-019 SHALL drive in ALU: asel=1 for opcode 110 (A forced to 0), else asel=0; bsel=0; loadc=1 for all except CMP; loads=1 only for CMP.
REQ-020 SHALL drive in WR_REG: writenum=Rd, vsel=00, write=1.
REQ-021 SHALL hold every strobe not listed for a state at 0; readnum/writenum SHALL be 000 when unused.
REQ-022 SHALL set latency from the s-sampling edge back to w=1: MOV imm 3 edges, MOV reg/MVN 5, CMP 5, ADD/AND 6.
REQ-023 SHALL make the IR update visible to DECODE when load=1 and s=1 coincide on the WAIT edge.
REQ-024 SHALL let a load during a busy state update IR immediately (remaining states use new fields); software loads only in WAIT.
REQ-025 SHALL drive sximm8, shift and ALUop combinationally from IR in every state.

Reset
REQ-026 SHALL force, on reset=0 at any time, including mid-instruction: state=WAIT, IR=0, w=1, err=0, all strobes 0, vsel=00, readnum=writenum=000.
REQ-027 SHALL leave WAIT only on the first rising clk edge with reset=1 and s=1; no write strobe SHALL occur during or after a reset-aborted instruction.

Verification
REQ-028 SHALL verify: IR=16'hD103 (MOV R1,#3), s pulse -> DECODE, WR_IMM with writenum=001, vsel=10, sximm8=3, write=1; w=1 after 3 edges.
REQ-029 SHALL verify: IR=16'hD6FD (MOV R6,#-3), IMM_SEXT=1 -> sximm8=16'hFFFD; IMM_SEXT=0 -> 16'h00FD.
REQ-030 SHALL verify: IR=16'hA269 (ADD R3,R2,R1 LSL1) -> GET_A readnum=010, GET_B readnum=001, shift=01, ALU loadc=1, WR_REG writenum=011; w=1 after 6 edges.
REQ-031 SHALL verify: IR=16'hAB84 (CMP R3,R4) -> loads=1 in ALU, loadc=0, write never asserted; w=1 after 5 edges.
REQ-032 SHALL verify: IR=16'hE000 (illegal) -> err=1 for one cycle in DECODE, then WAIT; reset=0 asserted in GET_B of an ADD -> immediate WAIT, IR=0, no write.
